memory_stage: RTL
=================

// Module: memory_stage
// PURPOSE
//  Y86-64 SEQ memory stage; sits directly downstream of execute.
//  Consumes icode/valE/valA/valP, performs the data-memory access and returns valM plus the Y86 status.
//  Runs a multi-cycle start/done handshake around an internal word-wide data RAM with programmable latency.
// PARAMETERS
//  DEPTH_WORDS  512  number of 64-bit data words; legal byte addresses are 0 .. DEPTH_WORDS*8-1
//  MEM_LAT      2    cycles from accept to done for a memory access (>=1)
// PORTS
//  clk          in   1   clock, rising-edge
//  reset        in   1   synchronous, active-high reset
//  start        in   1   request strobe; accepted only while ready=1
//  ready        out  1   1 in IDLE only
//  icode        in   4   instruction code, sampled on accept
//  instr_valid  in   1   fetch validity; 0 -> INS status, sampled on accept
//  imem_error   in   1   fetch address error; 1 -> ADR status, sampled on accept
//  valE         in   64  ALU result from execute
//  valA         in   64  register operand A
//  valP         in   64  next-PC value (call return address)
//  done         out  1   one-cycle pulse; valM/stat valid in that cycle and held after it
//  valM         out  64  read data (0 for non-read instructions)
//  stat         out  3   1=AOK 2=HLT 3=ADR 4=INS
// BEHAVIOUR
//  Reset: ready=1, done=0, valM=0, stat=AOK(1), FSM=IDLE. RAM contents are not reset.
//  All inputs are captured into internal registers on accept (start & ready); later input changes are ignored.
//  Address/data selection:
//   - rmmovq(4), pushq(A): write valA to M[valE]
//   - call(8): write valP to M[valE]
//   - mrmovq(5): read M[valE]
//   - ret(9), popq(B): read M[valA]
//   - all other icodes: no access
//  Word index = addr[ADDR_W+2:3]; little-endian 64-bit words.
//  Status priority (highest first): imem_error -> ADR; !instr_valid -> INS; icode==0 (halt) -> HLT;
//   access with addr >= DEPTH_WORDS*8 -> ADR; otherwise AOK.
//  Any non-AOK status suppresses the RAM write and forces valM=0.
//  FSM:
//   - IDLE: on accept, go to BUSY (loads counter=MEM_LAT-1) if the op accesses memory and status=AOK;
//     otherwise go to RESP.
//   - BUSY: decrement counter; at 0, commit write / capture read data, go to RESP.
//   - RESP: done=1 for one cycle, then IDLE.
//  Latency, accept to done: MEM_LAT+1 cycles for an access; 1 cycle for non-access or error.
//  start while ready=0 is ignored (no queueing).
//  A write commits only on the BUSY->RESP edge. Reset in BUSY aborts: no write, FSM=IDLE, outputs reset.
//  A read in the same op as no write needs no read-after-write bypass. Back-to-back ops see prior
//   committed writes.
// CONFIGURATION
//  ALIGN_CHECK_EN defined: access with addr[2:0]!=0 -> stat=ADR, no access, 1-cycle path.
//  ALIGN_CHECK_EN undefined: addr[2:0] ignored; access goes to the containing word.
// STRUCTURE
//  Package y86_pkg: icode localparams (IHALT..IPOPQ), stat codes (SAOK/SHLT/SADR/SINS), FSM state encoding.
//  One sub-module data_ram: single-port, synchronous write, registered read; DEPTH_WORDS x 64.
//  FSM, counter, address/data muxing and status logic stay in memory_stage.
// TESTING
//  1. rmmovq icode=4 valA=64'h637b8dbc90e27d04 valE=64'h40, then mrmovq icode=5 valE=64'h40
//     -> done at accept+3 (MEM_LAT=2), valM=64'h637b8dbc90e27d04, stat=1.
//  2. call icode=8 valP=64'h123 valE=64'h1F8, then ret icode=9 valA=64'h1F8
//     -> valM=64'h123, stat=1.
//  3. mrmovq valE=64'h1000 (=DEPTH_WORDS*8) -> done at accept+1, stat=3, valM=0;
//     a following read of 64'hFF8 is unchanged.
//  4. halt icode=0 -> stat=2 at accept+1. instr_valid=0 with icode=4 -> stat=4, no write.
//     imem_error=1 with instr_valid=0 -> stat=3.
//  5. Pulse reset in BUSY during rmmovq to 64'h80 -> ready=1, done never pulses;
//     a later read of 64'h80 returns the old data.
//  6. rmmovq valE=64'h43: ALIGN_CHECK_EN -> stat=3, no write; undefined -> word 64'h40 written, stat=1.
//     start held high while busy -> exactly one done per accept.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 instruction codes, status codes and memory-stage FSM states
package y86_pkg;
   localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, IRRMOVQ = 4'h2, IIRMOVQ = 4'h3,
                          IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ = 4'h6, IJXX = 4'h7,
                          ICALL = 4'h8, IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB;
   localparam logic [2:0] SAOK = 3'd1, SHLT = 3'd2, SADR = 3'd3, SINS = 3'd4;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/data_ram.sv
// data_ram: single-port word RAM, synchronous write, registered read
module data_ram #(
   parameter int DEPTH_WORDS = 512,
   parameter int ADDR_W = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [63:0]       wdata,
   output logic [63:0]       rdata
);
   logic [63:0] mem [DEPTH_WORDS];
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: Y86-64 SEQ memory stage with start/done handshake; ALIGN_CHECK_EN flags misaligned accesses as ADR
module memory_stage
   import y86_pkg::*;
#(
   parameter int DEPTH_WORDS = 512,
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        ready,
   input  logic [3:0]  icode,
   input  logic        instr_valid,
   input  logic        imem_error,
   input  logic [63:0] valE,
   input  logic [63:0] valA,
   input  logic [63:0] valP,
   output logic        done,
   output logic [63:0] valM,
   output logic [2:0]  stat
);
   localparam int ADDR_W = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(MEM_LAT + 1);
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic wr, rd, access, mis, accept, ram_we, wr_q, rd_q;
   logic [63:0] addr, wdata, wdata_q, rdata;
   logic [2:0] st;
   logic [ADDR_W-1:0] idx_q, ram_addr;
   always_comb begin
      wr = icode == IRMMOVQ || icode == IPUSHQ || icode == ICALL;
      rd = icode == IMRMOVQ || icode == IRET || icode == IPOPQ;
      access = wr || rd;
      addr = (icode == IRET || icode == IPOPQ) ? valA : valE;
      wdata = icode == ICALL ? valP : valA;
`ifdef ALIGN_CHECK_EN
      mis = access && addr[2:0] != 3'd0;
`else
      mis = 1'b0;
`endif
      st = imem_error ? SADR : !instr_valid ? SINS : icode == IHALT ? SHLT :
           (access && (addr >= 64'(DEPTH_WORDS) * 64'd8 || mis)) ? SADR : SAOK;
      ready = state == IDLE;
      done = state == RESP;
      accept = start && ready;
      state_n = state == IDLE ? (accept ? ((access && st == SAOK) ? BUSY : RESP) : IDLE) :
                state == BUSY ? (cnt == '0 ? RESP : BUSY) : IDLE;
      // reset must win over a commit landing on the same edge
      ram_we = state == BUSY && cnt == '0 && wr_q && !reset;
      // while idle the RAM already reads the live address so MEM_LAT=1 has data in time
      ram_addr = state == IDLE ? addr[ADDR_W+2:3] : idx_q;
   end
   always_ff @(posedge clk) begin
      if (accept) begin
         wr_q <= wr;
         rd_q <= rd;
         idx_q <= addr[ADDR_W+2:3];
         wdata_q <= wdata;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         valM <= '0;
         stat <= SAOK;
      end else begin
         state <= state_n;
         if (accept) cnt <= CW'(MEM_LAT - 1);
         else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
         if (accept && state_n == RESP) begin
            valM <= '0;
            stat <= st;
         end else if (state == BUSY && cnt == '0) begin
            valM <= rd_q ? rdata : '0;
            stat <= SAOK;
         end
      end
   end
   data_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
      .clk(clk),
      .we(ram_we),
      .addr(ram_addr),
      .wdata(wdata_q),
      .rdata(rdata)
   );
endmodule
